// File: rtl/sdram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_responder_if
// Description : SDRAM command/address bus between a controller (master) and
//               the sdram_responder device emulator (slave). The DQ bus is
//               kept as a module-level inout so that tristate resolution
//               happens at the pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_responder_if #(
  parameter int SDRADDR_WIDTH = 12,
  parameter int BANK_WIDTH    = 2
) ();
  logic [SDRADDR_WIDTH-1:0] addr;
  logic [BANK_WIDTH-1:0]    bank_addr;
  logic                     clock_enable;
  logic                     cs_n;
  logic                     ras_n;
  logic                     cas_n;
  logic                     we_n;
  logic                     data_mask_low;
  logic                     data_mask_high;

  modport master (
    output addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
           data_mask_low, data_mask_high
  );

  modport slave (
    input addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
          data_mask_low, data_mask_high
  );
endinterface
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module      : sdram_responder
// Description : SDRAM device emulator. Decodes controller commands, tracks the
//               init sequence, mode register, open rows, tRCD and refresh, and
//               serves single-word reads/writes from an on-chip store. The
//               first protocol violation is latched on sticky status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_responder #(
  parameter int ROW_WIDTH          = 12,
  parameter int COL_WIDTH          = 8,
  parameter int BANK_WIDTH         = 2,
  parameter int SDRADDR_WIDTH      = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
  parameter int STORE_AWIDTH       = 10,
  parameter int TRCD_CYCLES        = 2,
  parameter int REFRESH_MAX_CYCLES = 1100
) (
  input  logic              clk,
  input  logic              rst,
  sdram_responder_if.slave  bus,
  inout  wire  [15:0]       data,
  output logic              init_done,
  output logic              protocol_error,
  output logic [3:0]        error_code,
  output logic [15:0]       refresh_count
);

  localparam int NBANKS = 1 << BANK_WIDTH;
  localparam int TW     = $clog2(TRCD_CYCLES + 1);
  localparam int WW     = $clog2(REFRESH_MAX_CYCLES + 1);
  localparam logic [TW-1:0] TRCD_SAT = TW'(TRCD_CYCLES);
  localparam logic [WW-1:0] WD_MAX   = WW'(REFRESH_MAX_CYCLES);

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP   = 3'b111;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_REF   = 3'b001;
  localparam logic [2:0] CMD_MRS   = 3'b000;
  localparam logic [2:0] CMD_BST   = 3'b110;

  localparam logic [3:0] ERR_NONE       = 4'd0;
  localparam logic [3:0] ERR_INIT_ORDER = 4'd1;
  localparam logic [3:0] ERR_MODE       = 4'd2;
  localparam logic [3:0] ERR_ACT_OPEN   = 4'd3;
  localparam logic [3:0] ERR_CLOSED     = 4'd4;
  localparam logic [3:0] ERR_TRCD       = 4'd5;
  localparam logic [3:0] ERR_REF_OPEN   = 4'd6;
  localparam logic [3:0] ERR_REFRESH    = 4'd7;
  localparam logic [3:0] ERR_BUS        = 4'd8;

  typedef enum logic [2:0] {
    INIT_PALL = 3'd0,
    INIT_REF1 = 3'd1,
    INIT_REF2 = 3'd2,
    INIT_MRS  = 3'd3,
    READY     = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Status registers
  logic [3:0]    err_q;
  logic [15:0]   refcnt_q;
  logic          init_done_q;
  logic [2:0]    cl_q;
  logic [WW-1:0] wd_q;

  // Per-bank state
  logic [NBANKS-1:0]    open_q;
  logic [ROW_WIDTH-1:0] row_q [NBANKS];
  logic [TW-1:0]        tmr_q [NBANKS];

  // Store and read pipe (index 0 = word captured on the READ edge)
  logic [15:0] mem_q [1 << STORE_AWIDTH];
  logic [15:0] rd_word_q;
  logic [2:0]  pv_q;
  logic [1:0]  pm1_q, pm2_q, pm3_q;
  logic [15:0] pd2_q, pd3_q;

  // Command decode
  logic                    w_cmd_valid;
  logic [2:0]              w_cmd;
  logic                    w_a10;
  logic [BANK_WIDTH-1:0]   w_bank;
  logic                    w_mode_ok;
  logic [STORE_AWIDTH-1:0] w_saddr;
  logic                    w_act, w_rd, w_wr, w_pre_all, w_pre_one, w_ref, w_cl_load;
  logic                    w_close_one;
  logic [3:0]              w_err_cmd;
  logic                    w_wd_err;
  logic [3:0]              w_err_new;

  // Read drive stage
  logic        w_drv_v;
  logic [15:0] w_drv_d;
  logic [1:0]  w_drv_m;
  logic        w_oe_lo, w_oe_hi;

  assign w_cmd_valid = bus.clock_enable & ~bus.cs_n;
  assign w_cmd       = {bus.ras_n, bus.cas_n, bus.we_n};
  assign w_a10       = bus.addr[10];
  assign w_bank      = bus.bank_addr;
  // Burst length 1 and CAS latency 2 or 3 only
  assign w_mode_ok   = (bus.addr[2:0] == 3'b000) && (bus.addr[6:5] == 2'b01);
  // Upper address bits alias into the store on purpose
  assign w_saddr     = STORE_AWIDTH'({w_bank, row_q[w_bank], bus.addr[COL_WIDTH-1:0]});
  assign w_close_one = w_pre_one | ((w_rd | w_wr) & w_a10);

  assign w_drv_v = (cl_q == 3'd2) ? pv_q[1] : pv_q[2];
  assign w_drv_d = (cl_q == 3'd2) ? pd2_q   : pd3_q;
  assign w_drv_m = (cl_q == 3'd2) ? pm2_q   : pm3_q;

  // A write on the bus in the same cycle wins over the pending read word
  assign w_oe_lo = w_drv_v & ~w_drv_m[0] & ~w_wr;
  assign w_oe_hi = w_drv_v & ~w_drv_m[1] & ~w_wr;
  assign data[7:0]  = w_oe_lo ? w_drv_d[7:0]  : 8'hzz;
  assign data[15:8] = w_oe_hi ? w_drv_d[15:8] : 8'hzz;

  // Init/ready state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT_PALL;
    else     state_q <= state_d;
  end

  // Next state and command decode with protocol checks
  always_comb begin
    state_d   = state_q;
    w_act     = 1'b0;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_pre_all = 1'b0;
    w_pre_one = 1'b0;
    w_ref     = 1'b0;
    w_cl_load = 1'b0;
    w_err_cmd = ERR_NONE;
    if (w_cmd_valid && w_cmd != CMD_NOP && w_cmd != CMD_BST) begin
      case (state_q)
        INIT_PALL: begin
          if (w_cmd == CMD_PRE && w_a10) begin
            w_pre_all = 1'b1;
            state_d   = INIT_REF1;
          end else begin
            w_err_cmd = ERR_INIT_ORDER;
          end
        end
        INIT_REF1: begin
          if (w_cmd == CMD_REF) begin
            w_ref   = 1'b1;
            state_d = INIT_REF2;
          end else begin
            w_err_cmd = ERR_INIT_ORDER;
          end
        end
        INIT_REF2: begin
          if (w_cmd == CMD_REF) begin
            w_ref   = 1'b1;
            state_d = INIT_MRS;
          end else begin
            w_err_cmd = ERR_INIT_ORDER;
          end
        end
        INIT_MRS: begin
          if (w_cmd != CMD_MRS) begin
            w_err_cmd = ERR_INIT_ORDER;
          end else if (!w_mode_ok) begin
            w_err_cmd = ERR_MODE;
          end else begin
            w_cl_load = 1'b1;
            state_d   = READY;
          end
        end
        READY: begin
          case (w_cmd)
            CMD_ACT: begin
              w_act = 1'b1;
              if (open_q[w_bank]) w_err_cmd = ERR_ACT_OPEN;
            end
            CMD_READ, CMD_WRITE: begin
              w_rd = (w_cmd == CMD_READ);
              w_wr = (w_cmd == CMD_WRITE);
              if (!open_q[w_bank])                   w_err_cmd = ERR_CLOSED;
              else if (tmr_q[w_bank] < TRCD_SAT)     w_err_cmd = ERR_TRCD;
              else if (w_cmd == CMD_WRITE && w_drv_v) w_err_cmd = ERR_BUS;
            end
            CMD_PRE: begin
              w_pre_all = w_a10;
              w_pre_one = ~w_a10;
            end
            CMD_REF: begin
              w_ref = 1'b1;
              if (|open_q) w_err_cmd = ERR_REF_OPEN;
            end
            CMD_MRS: begin
              if (!w_mode_ok)   w_err_cmd = ERR_MODE;
              else if (~|open_q) w_cl_load = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_d = INIT_PALL;
      endcase
    end
  end

  // Watchdog fires once the cycles since the last REF exceed the limit
  assign w_wd_err  = (state_q == READY) && (wd_q >= WD_MAX) && !w_ref;
  assign w_err_new = (w_err_cmd != ERR_NONE) ? w_err_cmd :
                     (w_wd_err ? ERR_REFRESH : ERR_NONE);

  // Status, mode register, refresh counter and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= ERR_NONE;
      refcnt_q    <= '0;
      init_done_q <= 1'b0;
      cl_q        <= 3'd3;
      wd_q        <= '0;
    end else begin
      if (err_q == ERR_NONE) err_q <= w_err_new;
      if (w_ref) refcnt_q <= refcnt_q + 16'd1;
      init_done_q <= (state_d == READY);
      if (w_cl_load) cl_q <= bus.addr[6:4];
      if (state_q != READY || w_ref) wd_q <= '0;
      else if (wd_q < WD_MAX)        wd_q <= wd_q + WW'(1);
    end
  end

  // Bank open flags, open rows and ACT-to-access timers
  always_ff @(posedge clk) begin
    if (rst) begin
      open_q <= '0;
      for (int b = 0; b < NBANKS; b++) begin
        row_q[b] <= '0;
        tmr_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        if (w_act && w_bank == BANK_WIDTH'(b)) begin
          open_q[b] <= 1'b1;
          row_q[b]  <= bus.addr[ROW_WIDTH-1:0];
          tmr_q[b]  <= TW'(1);
        end else begin
          if (w_pre_all || (w_close_one && w_bank == BANK_WIDTH'(b))) open_q[b] <= 1'b0;
          if (tmr_q[b] < TRCD_SAT) tmr_q[b] <= tmr_q[b] + TW'(1);
        end
      end
    end
  end

  // Backing store with byte-lane writes; read word captured on the READ edge
  always_ff @(posedge clk) begin
    if (w_wr && !bus.data_mask_low)  mem_q[w_saddr][7:0]  <= data[7:0];
    if (w_wr && !bus.data_mask_high) mem_q[w_saddr][15:8] <= data[15:8];
    if (w_rd) rd_word_q <= mem_q[w_saddr];
  end

  // Read latency pipe; one word per cycle for back-to-back reads
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q  <= '0;
      pm1_q <= '0;
      pm2_q <= '0;
      pm3_q <= '0;
      pd2_q <= '0;
      pd3_q <= '0;
    end else begin
      pv_q  <= {pv_q[1:0], w_rd};
      if (w_rd) pm1_q <= {bus.data_mask_high, bus.data_mask_low};
      pm2_q <= pm1_q;
      pm3_q <= pm2_q;
      pd2_q <= rd_word_q;
      pd3_q <= pd2_q;
    end
  end

  assign init_done      = init_done_q;
  assign protocol_error = (err_q != ERR_NONE);
  assign error_code     = err_q;
  assign refresh_count  = refcnt_q;

endmodule
`default_nettype wire

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable SDRAM device emulator: the responder end of the SDRAM command bus.
- Decodes CKE/CS/RAS/CAS/WE commands from an SDRAM controller, tracks the init sequence, mode register, per-bank open rows, refresh and tRCD.
- Serves single-word reads and writes from an on-chip backing store.
- Used on-FPGA and in simulation to bring up and check the SDRAM controller without the external chip. Protocol violations are reported on sticky status outputs.

Parameters:
ROW_WIDTH, 12, row address bits
COL_WIDTH, 8, column address bits
BANK_WIDTH, 2, bank address bits
SDRADDR_WIDTH, max(ROW_WIDTH,COL_WIDTH), SDRAM address bus width
STORE_AWIDTH, 10, backing store depth is 2^STORE_AWIDTH 16-bit words
TRCD_CYCLES, 2, minimum edges from ACT to READ/WRITE on the same bank
REFRESH_MAX_CYCLES, 1100, maximum cycles allowed between REF commands once ready

Ports:
clk  in  1  system clock; all sampling on posedge
rst  in  1  synchronous reset, active-high
addr  in  SDRADDR_WIDTH  SDRAM address; A10 = auto-precharge / precharge-all
bank_addr  in  BANK_WIDTH  bank select
data  inout  16  DQ bus; driven only during a read data cycle, else high-Z
clock_enable  in  1  CKE
cs_n  in  1  chip select, active low
ras_n  in  1  row strobe
cas_n  in  1  column strobe
we_n  in  1  write enable
data_mask_low  in  1  DQM for bits 7:0, 1 = masked
data_mask_high  in  1  DQM for bits 15:8, 1 = masked
init_done  out  1  set once MRS completes a legal init sequence
protocol_error  out  1  sticky; set on the first violation
error_code  out  4  code of the first violation; 0 = none
refresh_count  out  16  REF commands accepted; wraps at 0xFFFF->0

Behaviour:
- Reset: init state INIT_PALL; all banks closed; read pipe empty; data high-Z; init_done=0; protocol_error=0; error_code=0; refresh_count=0; CL register=3. Backing store contents are not affected by rst.
- Command sampling: a command is sampled on a posedge with clock_enable=1 and cs_n=0.
  - cs_n=1 is a NOP.
  - clock_enable=0 ignores the bus entirely. Pipelines and timers still advance.
- {ras_n,cas_n,we_n} decode: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS, 110 BST (ignored, no error).
- Init FSM: INIT_PALL -> INIT_REF1 -> INIT_REF2 -> INIT_MRS -> READY.
  - Advancing commands, in order: PRE with A10=1, REF, REF, MRS.
  - NOP is legal in any init state.
  - Any other command during init -> error 1 (INIT_ORDER). The FSM stays in its state.
- MRS: A[2:0] must be 000 (burst length 1), else error 2. A[6:4] must be 010 or 011, else error 2.
  - On a legal MRS, CL latches A[6:4] and init_done goes 1 the next cycle.
  - A legal MRS in READY with all banks idle reloads CL.
- Bank state (per bank): open flag, row, and an ACT timer that saturates at TRCD_CYCLES.
  - ACT to an open bank -> error 3. ACT to a closed bank opens it with addr[ROW_WIDTH-1:0].
  - READ/WRITE to a closed bank -> error 4.
  - READ/WRITE with fewer than TRCD_CYCLES edges since that bank's ACT -> error 5. The access is still performed.
  - A10=1 on READ/WRITE closes the bank after the access.
  - PRE with A10=1 closes all banks; with A10=0 it closes bank_addr. PRE of an idle bank is legal.
  - REF with any bank open -> error 6. refresh_count still increments.
- Store address: low STORE_AWIDTH bits of {bank, row, col[COL_WIDTH-1:0]}. Aliasing above the store depth is intentional.
- WRITE: data is sampled on the same edge as the command. A byte lane is written only when its mask is 0.
- READ: the word at the store address and the DQM values are captured on the edge sampling READ, at edge k.
  - data is driven in the cycle following edge k+CL-1, for exactly one cycle. The controller samples it at edge k+CL.
  - A masked lane drives high-Z in that cycle.
  - Back-to-back READs pipeline: one word per cycle.
- WRITE sampled while a read word is in flight for the same cycle -> error 8 (BUS_CONTENTION). The write is performed and the read drive is cancelled.
- Refresh watchdog: counts cycles since the last REF, starting from entry to READY. Exceeding REFRESH_MAX_CYCLES -> error 7.
- Error capture: only the first error is recorded. If a command error and error 7 occur on the same edge, the command error wins. Errors never block operation.
- Reset mid-read: the pipe is flushed and data is high-Z from the cycle after the rst edge.

Test Plan:
- Init sequence PRE(A10=1), REF, REF, MRS addr=0x230 -> init_done=1, CL=3, refresh_count=2, error_code=0.
- WRITE 0xBEEF at bank 1/row 5/col 0x12 (ACT, 3 NOPs, WRITE A10=1), then READ the same address -> data=0xBEEF sampled exactly 3 edges after READ, high-Z before and after.
- WRITE 0x1234 with data_mask_high=1 over 0xFFFF -> readback 0xFF34. READ with data_mask_low=1 -> bits 7:0 high-Z.
- READ issued 1 edge after ACT -> error_code=5, protocol_error=1. A later ACT to the still-open bank leaves error_code at 5.
- REF before the initial PRE -> error_code=1, init_done stays 0. Apply rst -> all status fields clear.
- After init, idle for 1101 cycles with no REF -> error_code=7. A MRS with A[6:4]=001 after reset and init -> error_code=2.
